// File: rtl/alu_pkg.sv
// alu_pkg: opcode/funct encodings and immediate extension helpers shared by the ALU and its bench.
package alu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  function automatic logic [31:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction
  function automatic logic [31:0] zero_ext(input logic [15:0] imm);
    return {16'h0, imm};
  endfunction
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath producing the result and branch-taken flag.
module alu_core
  import alu_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic [31:0] result_o,
  output logic        branch_o
);
  logic [31:0] diff, simm, zimm;
  assign diff = rs_i - rt_i;
  assign simm = sign_ext(imm_i);
  assign zimm = zero_ext(imm_i);
  always_comb begin
    result_o = '0;
    branch_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: case (funct_i)
        F_ADD, F_ADDU: result_o = rs_i + rt_i;
        F_SUB, F_SUBU: result_o = diff;
        F_AND:         result_o = rs_i & rt_i;
        F_OR:          result_o = rs_i | rt_i;
        F_XOR:         result_o = rs_i ^ rt_i;
        F_NOR:         result_o = ~(rs_i | rt_i);
        F_SLT:         result_o = {31'b0, $signed(rs_i) < $signed(rt_i)};
        F_SLTU:        result_o = {31'b0, rs_i < rt_i};
        F_SLL:         result_o = rt_i << shamt_i;
        F_SRL:         result_o = rt_i >> shamt_i;
        F_SRA:         result_o = 32'($signed(rt_i) >>> shamt_i);
        F_SLLV:        result_o = rt_i << rs_i[4:0];
        F_SRLV:        result_o = rt_i >> rs_i[4:0];
        F_SRAV:        result_o = 32'($signed(rt_i) >>> rs_i[4:0]);
        default:       result_o = '0;
      endcase
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: result_o = rs_i + simm;
      OP_SLTI:  result_o = {31'b0, $signed(rs_i) < $signed(simm)};
      OP_SLTIU: result_o = {31'b0, rs_i < simm};
      OP_ANDI:  result_o = rs_i & zimm;
      OP_ORI:   result_o = rs_i | zimm;
      OP_XORI:  result_o = rs_i ^ zimm;
      OP_LUI:   result_o = {imm_i, 16'h0};
      OP_BEQ: begin
        result_o = diff;
        branch_o = rs_i == rt_i;
      end
      OP_BNE: begin
        result_o = diff;
        branch_o = rs_i != rt_i;
      end
      OP_BLEZ: begin
        result_o = diff;
        branch_o = rs_i[31] || rs_i == '0;
      end
      OP_BGTZ: begin
        result_o = diff;
        branch_o = !rs_i[31] && rs_i != '0;
      end
      default: result_o = '0;
    endcase
  end
endmodule

// File: rtl/alu_unit.sv
// alu_unit: one-cycle registered ALU wrapping alu_core.
module alu_unit
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  input  logic [4:0]  shamt,
  input  logic [5:0]  ALU_control,
  input  logic [15:0] immediate,
  output logic [31:0] ALU_result,
  output logic        sig_branch
);
  logic [31:0] result_d, result_q;
  logic        branch_d, branch_q;
  alu_core u_core (
    .opcode_i(opcode),
    .rs_i(rs_content),
    .rt_i(rt_content),
    .shamt_i(shamt),
    .funct_i(ALU_control),
    .imm_i(immediate),
    .result_o(result_d),
    .branch_o(branch_d)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      branch_q <= 1'b0;
    end else begin
      result_q <= result_d;
      branch_q <= branch_d;
    end
  end
  assign ALU_result = result_q;
  assign sig_branch = branch_q;
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed-vector bench for alu_unit with hand-computed expectations.
module tb_alu_unit;
  import alu_pkg::*;
  logic        clk, rst_n;
  logic [5:0]  opcode, alu_control;
  logic [31:0] rs_content, rt_content;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [31:0] alu_result;
  logic        sig_branch;
  int n_assert = 0;
  int n_fail = 0;
  alu_unit dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .rs_content(rs_content),
    .rt_content(rt_content),
    .shamt(shamt),
    .ALU_control(alu_control),
    .immediate(immediate),
    .ALU_result(alu_result),
    .sig_branch(sig_branch)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] er, input logic eb);
    n_assert++;
    assert (alu_result === er) else begin
      n_fail++;
      $error("FAIL %s result: got %h expected %h", tag, alu_result, er);
    end
    n_assert++;
    assert (sig_branch === eb) else begin
      n_fail++;
      $error("FAIL %s branch: got %b expected %b", tag, sig_branch, eb);
    end
  endtask
  task automatic step(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                      input string tag, input logic [31:0] er, input logic eb);
    @(negedge clk);
    opcode = op; rs_content = rs; rt_content = rt; shamt = sh; alu_control = fn; immediate = imm;
    @(posedge clk);
    #1 chk(tag, er, eb);
  endtask
  initial begin
    rst_n = 1'b0;
    opcode = OP_LUI; rs_content = '0; rt_content = '0; shamt = '0; alu_control = '0; immediate = 16'hBEEF;
    #3 chk("reset_async", 32'h0, 1'b0);
    @(posedge clk);
    #1 chk("reset_hold", 32'h0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step(OP_LW,    32'd15,        32'd0,         5'd0, 6'd0,   16'd19,    "lw1",     32'd34,        1'b0);
    step(OP_LW,    32'd23,        32'd0,         5'd0, 6'd0,   16'd14,    "lw2",     32'd37,        1'b0);
    step(OP_LW,    32'd1,         32'd0,         5'd0, 6'd0,   16'd8,     "lw3",     32'd9,         1'b0);
    step(OP_SW,    32'h64,        32'd0,         5'd0, 6'd0,   16'hFFFC,  "sw_neg",  32'h60,        1'b0);
    step(OP_RTYPE, 32'd5,         32'd7,         5'd0, F_SUB,  16'd0,     "sub",     32'hFFFFFFFE,  1'b0);
    step(OP_RTYPE, 32'd5,         32'd7,         5'd0, F_SLT,  16'd0,     "slt",     32'd1,         1'b0);
    step(OP_RTYPE, 32'hFFFFFFFF,  32'd1,         5'd0, F_SLT,  16'd0,     "slt_neg", 32'd1,         1'b0);
    step(OP_RTYPE, 32'hFFFFFFFF,  32'd1,         5'd0, F_SLTU, 16'd0,     "sltu",    32'd0,         1'b0);
    step(OP_RTYPE, 32'hFFFFFFFF,  32'd2,         5'd0, F_ADDU, 16'd0,     "add_wrap",32'd1,         1'b0);
    step(OP_RTYPE, 32'hF0F0F0F0,  32'h0F0F00FF,  5'd0, F_AND,  16'd0,     "and",     32'h000000F0,  1'b0);
    step(OP_RTYPE, 32'h0,         32'h0,         5'd0, F_NOR,  16'd0,     "nor",     32'hFFFFFFFF,  1'b0);
    step(OP_RTYPE, 32'hA5A5A5A5,  32'hFFFF0000,  5'd0, F_XOR,  16'd0,     "xor",     32'h5A5AA5A5,  1'b0);
    step(OP_RTYPE, 32'd0,         32'h80000000,  5'd4, F_SRA,  16'd0,     "sra",     32'hF8000000,  1'b0);
    step(OP_RTYPE, 32'd0,         32'h80000000,  5'd4, F_SRL,  16'd0,     "srl",     32'h08000000,  1'b0);
    step(OP_RTYPE, 32'd0,         32'h00000003,  5'd3, F_SLL,  16'd0,     "sll",     32'h00000018,  1'b0);
    step(OP_RTYPE, 32'd33,        32'h12345678,  5'd9, F_SLLV, 16'd0,     "sllv",    32'h2468ACF0,  1'b0);
    step(OP_RTYPE, 32'd36,        32'h80000000,  5'd0, F_SRAV, 16'd0,     "srav",    32'hF8000000,  1'b0);
    step(OP_RTYPE, 32'd5,         32'd7,         5'd0, 6'b111111, 16'd0,  "bad_fn",  32'd0,         1'b0);
    step(OP_BEQ,   32'd9,         32'd9,         5'd0, 6'd0,   16'd0,     "beq",     32'd0,         1'b1);
    step(OP_BNE,   32'd9,         32'd9,         5'd0, 6'd0,   16'd0,     "bne",     32'd0,         1'b0);
    step(OP_BNE,   32'd9,         32'd4,         5'd0, 6'd0,   16'd0,     "bne_t",   32'd5,         1'b1);
    step(OP_BGTZ,  32'd0,         32'd5,         5'd0, 6'd0,   16'd0,     "bgtz0",   32'hFFFFFFFB,  1'b0);
    step(OP_BGTZ,  32'd1,         32'd0,         5'd0, 6'd0,   16'd0,     "bgtz1",   32'd1,         1'b1);
    step(OP_BLEZ,  32'hFFFFFFFF,  32'd0,         5'd0, 6'd0,   16'd0,     "blez",    32'hFFFFFFFF,  1'b1);
    step(OP_BLEZ,  32'd1,         32'd0,         5'd0, 6'd0,   16'd0,     "blez_nt", 32'd1,         1'b0);
    step(OP_ADDI,  32'd0,         32'd0,         5'd0, 6'd0,   16'hFFFF,  "addi",    32'hFFFFFFFF,  1'b0);
    step(OP_SLTI,  32'hFFFFFFFE,  32'd0,         5'd0, 6'd0,   16'hFFFF,  "slti",    32'd1,         1'b0);
    step(OP_SLTIU, 32'd5,         32'd0,         5'd0, 6'd0,   16'hFFFF,  "sltiu",   32'd1,         1'b0);
    step(OP_ANDI,  32'hFFFFFFFF,  32'd0,         5'd0, 6'd0,   16'hFFFF,  "andi",    32'h0000FFFF,  1'b0);
    step(OP_ORI,   32'h12340000,  32'd0,         5'd0, 6'd0,   16'h8001,  "ori",     32'h12348001,  1'b0);
    step(OP_XORI,  32'hF0F0F0F0,  32'd0,         5'd0, 6'd0,   16'h00FF,  "xori",    32'hF0F0F00F,  1'b0);
    step(OP_LUI,   32'hFFFFFFFF,  32'd0,         5'd0, 6'd0,   16'h1234,  "lui",     32'h12340000,  1'b0);
    step(6'b111111,32'd7,         32'd7,         5'd0, 6'd0,   16'h1234,  "bad_op",  32'd0,         1'b0);
    step(OP_LUI,   32'd0,         32'd0,         5'd0, 6'd0,   16'h1234,  "pre_rst", 32'h12340000,  1'b0);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid", 32'h0, 1'b0);
    @(posedge clk);
    #1 chk("rst_held", 32'h0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_rel", 32'h0, 1'b0);
    @(posedge clk);
    #1 chk("post_rst", 32'h12340000, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction opcode field.
REQ-004 SHALL have port rs_content, input, 32 bits: first operand (rs register value).
REQ-005 SHALL have port rt_content, input, 32 bits: second operand (rt register value).
REQ-006 SHALL have port shamt, input, 5 bits: shift amount for constant shifts.
REQ-007 SHALL have port ALU_control, input, 6 bits: funct field, used only when opcode = 000000.
REQ-008 SHALL have port immediate, input, 16 bits: I-type immediate.
REQ-009 SHALL have port ALU_result, output, 32 bits: registered result.
REQ-010 SHALL have port sig_branch, output, 1 bit: registered branch-taken flag.

Function
REQ-011 SHALL sample all inputs on each rising clk edge and present ALU_result/sig_branch after that edge; latency 1 cycle, throughput 1 operation per cycle, no handshake.
REQ-012 SHALL define SignExt(imm) as imm[15] replicated to 32 bits and ZeroExt(imm) as 16 zeros prepended.
REQ-013 SHALL, for opcode 000000, select by ALU_control: 100000/100001 add; 100010/100011 rs-rt; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 signed rs<rt ? 1 : 0; 101011 unsigned compare.
REQ-014 SHALL, for opcode 000000, implement shifts on rt: 000000 sll by shamt; 000010 srl by shamt; 000011 sra by shamt; 000100/000110/000111 sllv/srlv/srav by rs[4:0].
REQ-015 SHALL implement I-type ops: 001000/001001 rs+SignExt; 001010 signed slti; 001011 sltiu (unsigned compare against SignExt); 001100 andi, 001101 ori, 001110 xori (all ZeroExt); 001111 lui = {immediate,16'h0}.
REQ-016 SHALL compute memory addresses for 100011 (lw) and 101011 (sw) as rs_content + SignExt(immediate).
REQ-017 SHALL set sig_branch=1 for: 000100 beq when rs==rt; 000101 bne when rs!=rt; 000110 blez when signed rs<=0; 000111 bgtz when signed rs>0; otherwise 0. For branches ALU_result SHALL be rs_content - rt_content.
REQ-018 SHALL wrap all add/sub modulo 2^32; no overflow trap or flag.
REQ-019 SHALL drive ALU_result=0 and sig_branch=0 for any unlisted opcode or funct.
REQ-020 SHALL keep sig_branch=0 for every non-branch opcode.

Reset
REQ-021 SHALL force ALU_result=32'h0 and sig_branch=0 immediately on rst_n low, independent of clk.
REQ-022 SHALL hold outputs at reset values while rst_n is low; the first result appears on the first rising edge after rst_n deasserts.
REQ-023 SHALL discard any operation in flight when reset asserts mid-operation.

Structure
REQ-024 SHALL place opcode and funct encodings as named constants in a shared package alu_pkg, reused by the decoder and the bench.
REQ-025 SHALL split into a combinational datapath sub-module alu_core (result and branch) plus an output register stage in alu_unit.

Verification
REQ-026 lw: opcode=100011, rs=15, imm=19 -> ALU_result=34 one cycle later; rs=23, imm=14 -> 37; rs=1, imm=8 -> 9; sig_branch=0 throughout.
REQ-027 R-type: opcode=0, funct=100010, rs=5, rt=7 -> ALU_result=FFFFFFFE; funct=101010 -> 1; funct=101011, rs=FFFFFFFF, rt=1 -> 0.
REQ-028 Shifts: funct=000011, rt=80000000, shamt=4 -> F8000000; funct=000010 -> 08000000; funct=000100, rs=33 -> rt<<1.
REQ-029 Branches: beq, rs=rt=9 -> sig_branch=1, result 0; bne on same operands -> 0; bgtz rs=0 -> 0; blez rs=FFFFFFFF -> 1.
REQ-030 Immediates: addi rs=0, imm=FFFF -> FFFFFFFF; andi rs=FFFFFFFF, imm=FFFF -> 0000FFFF; lui imm=1234 -> 12340000; unknown opcode 111111 -> 0.
REQ-031 Reset: assert rst_n low between clock edges mid-stream -> outputs 0 immediately; release -> correct result after next edge.
